// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor.
package serial_arith_pkg;

  // Encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << n) < w) n++;
    end
    return (n < 1) ? 1 : n;
  endfunction

endpackage

// File: rtl/bit_serial_addsub_if.sv
// Operand/result handshake bundle for bit_serial_addsub, plus FSM state for observation.
interface bit_serial_addsub_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
);
  // Both sides: a transfer happens on a rising edge where valid && ready are both high.
  // in_ready is high only in IDLE; out_valid is high only in DONE and holds with its
  // payload until out_ready is seen.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             busy;
  state_t           fsm_state;

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, result, cout, busy, fsm_state
  );

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, result, cout, busy, fsm_state
  );
endinterface

// File: rtl/full_adder_df.sv
// Dataflow 1-bit full adder cell.
module full_adder_df (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/bit_serial_addsub.sv
// Bit-serial add/subtract: one full-adder cell and a carry flop, LSB first, WIDTH cycles per op.
module bit_serial_addsub
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_addsub_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             carry;
  logic             sub_q;
  logic [CW-1:0]    cnt;
  logic             fa_sum;
  logic             fa_cout;
  logic             accept;

  assign accept = bus.in_valid && (state == IDLE);

  full_adder_df u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB; after WIDTH shifts the LSB has reached bit 0.
  assign res_next = WIDTH'({fa_sum, res_sh} >> 1);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      sub_q  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        // Subtraction is a + ~b + ~bin; the final carry is then inverted into a borrow.
        a_sh  <= bus.a;
        b_sh  <= bus.sub ? ~bus.b : bus.b;
        carry <= bus.sub ? ~bus.cin : bus.cin;
        sub_q <= bus.sub;
        cnt   <= '0;
      end else if (state == RUN) begin
        carry  <= fa_cout;
        res_sh <= res_next;
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.result    = res_sh;
  assign bus.cout      = sub_q ? ~carry : carry;
  assign bus.fsm_state = state;

endmodule
